mem_access_seq: RTL

- Parametrised memory-access sequencer for the RISC datapath; successor to the fixed 5-step load-only sequencer.
- Runs both LOAD and STORE transactions through the MAR/MDR pair, owning the MAR and MDR registers internally.
- Drives the MARin, MDRin, MDRout, mem_read and mem_write strobes, with configurable memory latency and a start/busy/done handshake to the control unit.

---
 rtl/mem_access_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// Memory-access sequencer: runs LOAD and STORE transactions through an internal MAR/MDR pair
// with configurable read/write latency and a start/busy/done handshake to the control unit.
module mem_access_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat) + 1;
    localparam logic [CntW-1:0] RdLast = CntW'(RD_LAT - 1);
    localparam logic [CntW-1:0] WrLast = CntW'(WR_LAT - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StRd, StCap, StDrv, StWld, StWr, StWdn
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = is_store;
                    addr_d  = addr;
                    data_d  = store_data;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                mar_d   = addr_q;
                state_d = op_q ? StWld : StRd;
            end
            StRd: begin
                if (cnt_q == RdLast) begin
                    cnt_d   = '0;
                    state_d = StCap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCap: begin
                mdr_d   = mem_rdata;
                state_d = StDrv;
            end
            StDrv: state_d = StIdle;
            StWld: begin
                mdr_d   = data_q;
                state_d = StWr;
            end
            StWr: begin
                if (cnt_q == WrLast) begin
                    cnt_d   = '0;
                    state_d = StWdn;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWdn:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Strobes decode from state alone so no input reaches an output combinationally.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle: ;
            StAddr: begin
                MARin = 1'b1;
                busy  = 1'b1;
            end
            StRd: begin
                mem_read = 1'b1;
                busy     = 1'b1;
            end
            StCap: begin
                MDRin = 1'b1;
                busy  = 1'b1;
            end
            StDrv: begin
                MDRout = 1'b1;
                done   = 1'b1;
                busy   = 1'b1;
            end
            StWld: begin
                MDRin = 1'b1;
                busy  = 1'b1;
            end
            StWr: begin
                mem_write = 1'b1;
                busy      = 1'b1;
            end
            StWdn: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign load_data = mdr_q;

endmodule
